// File: rtl/uart_pkg.sv
// Shared encodings and default parameters for the UART receive-side controller.
package uart_pkg;

    localparam int DATA_BITS_DEF    = 8;
    localparam int OVERSAMPLING_DEF = 8;
    localparam int DIV_WIDTH_DEF    = 16;
    localparam int DIV_RESET_DEF    = 53;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int IDLE_BITS_DEF    = 20;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RUN    = 2'd1,
        ST_RELOAD = 2'd2
    } ctrl_state_e;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with occupancy count; a write on full is accepted only
// when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    localparam int AW       = $clog2(DEPTH),
    localparam int LW       = AW + 1
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic                 wr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic                 rd_i,
    output logic [DATA_BITS-1:0] rd_data_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 drop_o,
    output logic [LW-1:0]        level_o
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic                 push;
    logic                 pop;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LW'(DEPTH));
    assign pop       = rd_i && !empty_o;
    assign push      = wr_i && (!full_o || pop);
    assign drop_o    = wr_i && full_o && !pop;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: baud tick divider, character capture into a FIFO,
// sticky overrun flag and idle-line detection.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_OFF    | disabled; tick counter held at 0, no capture
//   ST_RUN    | ticks generated, characters captured
//   ST_RELOAD | one quiet cycle after a divisor load; capture still open
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int OVERSAMPLING = OVERSAMPLING_DEF,
    parameter int DIV_WIDTH    = DIV_WIDTH_DEF,
    parameter int DIV_RESET    = DIV_RESET_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int IDLE_BITS    = IDLE_BITS_DEF,
    localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 sysclk_in,
    input  logic                 nrst_in,
    input  logic                 en_in,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 div_load_in,
    output logic                 baud_tick_out,
    input  logic                 rx_rdy_in,
    input  logic [DATA_BITS-1:0] rx_data_in,
    output logic [DATA_BITS-1:0] m_data_out,
    output logic                 m_valid_out,
    input  logic                 m_ready_in,
    output logic                 overrun_out,
    input  logic                 overrun_clr_in,
    output logic                 idle_out,
    output logic [LW-1:0]        level_out
);

    localparam int IDLE_LIMIT = IDLE_BITS * OVERSAMPLING;
    localparam int IW         = cnt_width(IDLE_LIMIT);

    ctrl_state_e          state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rdy_prev_q;
    logic                 overrun_q, overrun_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 idle_q, idle_d;
    logic                 capture;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_drop;

    assign baud_tick_out = (state_q == ST_RUN) && (cnt_q == div_q);
    assign capture       = rx_rdy_in && !rdy_prev_q && (state_q != ST_OFF);
    assign m_valid_out   = !fifo_empty;
    assign overrun_out   = overrun_q;
    assign idle_out      = idle_q;

    uart_rx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (sysclk_in),
        .nrst_i    (nrst_in),
        .wr_i      (capture),
        .wr_data_i (rx_data_in),
        .rd_i      (m_ready_in),
        .rd_data_o (m_data_out),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .drop_o    (fifo_drop),
        .level_o   (level_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:    state_d = (en_in && !div_load_in) ? ST_RUN : ST_OFF;
            ST_RUN,
            ST_RELOAD: begin
                if (!en_in)           state_d = ST_OFF;
                else if (div_load_in) state_d = ST_RELOAD;
                else                  state_d = ST_RUN;
            end
            default:   state_d = ST_OFF;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN && !baud_tick_out) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Saturation keeps the idle pulse to once per captured character.
        idle_cnt_d = idle_cnt_q;
        idle_d     = 1'b0;
        if (capture) begin
            idle_cnt_d = '0;
        end else if (baud_tick_out && idle_cnt_q != IW'(IDLE_LIMIT)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
            idle_d     = (idle_cnt_q == IW'(IDLE_LIMIT - 1)) && !fifo_empty;
        end

        overrun_d = overrun_q;
        if (fifo_drop)           overrun_d = 1'b1;
        else if (overrun_clr_in) overrun_d = 1'b0;
    end

    always_ff @(posedge sysclk_in) begin
        if (!nrst_in) begin
            state_q    <= ST_OFF;
            div_q      <= DIV_WIDTH'(DIV_RESET);
            cnt_q      <= '0;
            rdy_prev_q <= 1'b0;
            overrun_q  <= 1'b0;
            idle_cnt_q <= '0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdy_prev_q <= rx_rdy_in;
            overrun_q  <= overrun_d;
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
            if (div_load_in) begin
                div_q <= div_in;
            end
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8, receiver character width.
REQ-002 Parameter OVERSAMPLING, default 8, ticks per bit expected by the receiver.
REQ-003 Parameter DIV_WIDTH, default 16, divisor register width.
REQ-004 Parameter DIV_RESET, default 53, divisor value after reset.
REQ-005 Parameter FIFO_DEPTH, default 4, power of two, >= 2.
REQ-006 Parameter IDLE_BITS, default 20, bit-times of silence before idle report.
REQ-007 sysclk_in  in  1  system clock, all logic on rising edge.
REQ-008 nrst_in  in  1  reset, synchronous, active-low.
REQ-009 en_in  in  1  level; enables tick generation and character capture.
REQ-010 div_in  in  DIV_WIDTH  new divisor (sysclk cycles per tick minus 1).
REQ-011 div_load_in  in  1  one-cycle pulse; latches div_in.
REQ-012 baud_tick_out  out  1  oversample tick enable for the receiver.
REQ-013 rx_rdy_in  in  1  character-ready from receiver; may stay high several cycles.
REQ-014 rx_data_in  in  DATA_BITS  received character, valid while rx_rdy_in high.
REQ-015 m_data_out  out  DATA_BITS  FIFO head character.
REQ-016 m_valid_out  out  1  FIFO non-empty.
REQ-017 m_ready_in  in  1  consumer accept.
REQ-018 overrun_out  out  1  sticky; character dropped on full FIFO.
REQ-019 overrun_clr_in  in  1  pulse; clears overrun_out.
REQ-020 idle_out  out  1  one-cycle idle-line pulse.
REQ-021 level_out  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-022 Controller SHALL have states OFF, RUN, RELOAD; OFF->RUN when en_in high; RUN/RELOAD->OFF when en_in low; RUN->RELOAD on div_load_in; RELOAD->RUN after exactly one cycle.
REQ-023 In RUN, tick counter SHALL increment per cycle; at count==div_reg it SHALL wrap to 0 and baud_tick_out SHALL be high that cycle only; div_reg=0 gives tick every cycle.
REQ-024 In OFF and RELOAD, counter SHALL be 0 and baud_tick_out low.
REQ-025 div_load_in SHALL update div_reg and zero the counter in any state; in OFF state stays OFF.
REQ-026 Capture SHALL occur on rx_rdy_in rising edge (registered previous value) only in RUN or RELOAD; one write per edge.
REQ-027 m_valid_out SHALL rise the cycle after the capture edge on an empty FIFO; m_data_out show-ahead from head.
REQ-028 Pop SHALL occur on m_valid_out & m_ready_in; m_ready_in on empty ignored.
REQ-029 Write on full FIFO without simultaneous pop SHALL be dropped and set overrun_out; write with simultaneous pop on full SHALL be accepted.
REQ-030 overrun_clr_in SHALL clear overrun_out; simultaneous set wins.
REQ-031 Idle counter SHALL count ticks since last capture, saturate, and zero on capture; reaching IDLE_BITS*OVERSAMPLING with FIFO non-empty SHALL pulse idle_out once per capture.
REQ-032 en_in low SHALL retain FIFO contents; consumer may still drain.
REQ-033 level_out SHALL equal writes minus pops, 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-034 On nrst_in low at a clock edge: state OFF, div_reg=DIV_RESET, counters and pointers 0, all outputs 0, edge register 0.
REQ-035 Reset mid-character or mid-drain SHALL discard FIFO contents; no capture in the first cycle after reset release.

Structure
REQ-036 State encodings and default parameter values SHALL live in shared package uart_pkg.
REQ-037 FIFO SHALL be sub-module uart_rx_fifo (show-ahead, full/empty/level); controller, divider, edge detect, idle logic in uart_rx_ctrl.

Verification
REQ-038 div_in=3, load, en_in=1 -> baud_tick_out every 4th cycle; reload to 0 -> one tick-free cycle, then tick every cycle.
REQ-039 rx_rdy_in high 5 cycles with 0xA5 -> exactly one entry; m_valid_out next cycle, m_data_out=0xA5, level_out=1.
REQ-040 Five captures, m_ready_in=0, depth 4 -> level_out=4, overrun_out=1, head 1st character; clear -> 0.
REQ-041 Full FIFO, capture and pop same cycle -> level_out stays 4, overrun_out stays 0.
REQ-042 div=0, OVERSAMPLING=8, one capture, no pop -> idle_out single pulse 160 ticks later, none further.
REQ-043 nrst_in low with level 3 -> next cycle level_out=0, m_valid_out=0, state OFF, div_reg=DIV_RESET.
